// File: rtl/i8008_pkg.sv
// Shared 8008 bus definitions: T-state encodings, cycle types, responder FSM states and the RST opcode suffix.
package i8008_pkg;

  typedef enum logic [2:0] {
    T_WAIT    = 3'b000,
    T_T3      = 3'b001,
    T_T1      = 3'b010,
    T_STOPPED = 3'b011,
    T_T2      = 3'b100,
    T_T5      = 3'b101,
    T_T1I     = 3'b110,
    T_T4      = 3'b111
  } t_state_t;

  // Cycle type carried in hi[7:6] of the T2 address byte.
  typedef enum logic [1:0] {
    CYC_PCI = 2'b00,
    CYC_PCC = 2'b01,
    CYC_PCR = 2'b10,
    CYC_PCW = 2'b11
  } cyc_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_IO_WAIT = 3'd4
  } resp_state_t;

  localparam logic [2:0] RST_SUFFIX = 3'b101;

  function automatic logic [7:0] rst_opcode(input logic [2:0] vec);
    return {2'b00, vec, RST_SUFFIX};
  endfunction

endpackage

// File: rtl/i8008_bus_responder.sv
// Bridges the 8008 T-state bus to a single-outstanding request/ack memory+I/O port.
// Reads stall the core via cpu_ready; writes are posted and a following request is held until the ack.
module i8008_bus_responder
  import i8008_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  cpu_state,
  input  logic        cpu_sync,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ready,
  output logic        cpu_intr,
  input  logic        irq_req,
  input  logic [2:0]  irq_vec,
  output logic [13:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        bus_io,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  resp_state_t state, state_n;
  logic [7:0]  lo, lo_n, hi, hi_n, req_hi;
  logic        intack, intack_n;
  logic        pend, pend_n;       // T2 seen while a posted write was outstanding
  logic        next_cyc, next_n;   // T1 of the following cycle already latched
  logic        wr_sent, sent_n;    // PCW write pulse already issued
  logic        rd_op, rdop_n;      // outstanding request returns data
  logic [7:0]  din_n, wdata_n;
  logic [13:0] addr_n;
  logic        ready_n, intr_n, rd_n, wr_n, io_n;
  logic        t1, t1i, t2, t3, do_issue;

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    intack_n = intack;
    pend_n   = pend;
    next_n   = next_cyc;
    sent_n   = wr_sent;
    rdop_n   = rd_op;
    din_n    = cpu_din;
    ready_n  = cpu_ready;
    intr_n   = cpu_intr;
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    io_n     = bus_io;
    do_issue = 1'b0;
    req_hi   = hi;

    t1  = cpu_sync && (cpu_state == T_T1 || cpu_state == T_T1I);
    t1i = cpu_sync && (cpu_state == T_T1I);
    t2  = cpu_sync && (cpu_state == T_T2);
    t3  = cpu_sync && (cpu_state == T_T3);

    // Clear wins for one cycle so a held request re-asserts on the next.
    if (t1i)
      intr_n = 1'b0;
    else if (irq_req)
      intr_n = 1'b1;

    case (state)
      ST_IDLE: begin
        if (t1) begin
          lo_n     = cpu_dout;
          intack_n = t1i;
          state_n  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (t1) begin
          lo_n     = cpu_dout;
          intack_n = t1i;
        end else if (t2) begin
          hi_n     = cpu_dout;
          req_hi   = cpu_dout;
          do_issue = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (t1) begin
          lo_n     = cpu_dout;
          intack_n = t1i;
          ready_n  = 1'b1;
          state_n  = ST_ADDR;
        end else if (mem_ack) begin
          din_n   = mem_rdata;
          ready_n = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_WR_WAIT, ST_IO_WAIT: begin
        if (state == ST_WR_WAIT && !wr_sent) begin
          if (t3) begin
            wr_n    = 1'b1;
            wdata_n = cpu_dout;
            addr_n  = {hi[5:0], lo};
            io_n    = 1'b0;
            sent_n  = 1'b1;
          end
        end else begin
          if (t1) begin
            lo_n     = cpu_dout;
            intack_n = t1i;
            next_n   = 1'b1;
          end else if (t2 && !pend) begin
            hi_n    = cpu_dout;
            pend_n  = 1'b1;
            ready_n = 1'b0;
          end
          if (mem_ack) begin
            if (rd_op)
              din_n = mem_rdata;
            ready_n = 1'b1;
            state_n = ST_IDLE;
            next_n  = 1'b0;
            if (pend_n) begin
              req_hi   = hi_n;
              do_issue = 1'b1;
            end else if (next_n || t1 || next_cyc) begin
              state_n = ST_ADDR;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (do_issue) begin
      pend_n   = 1'b0;
      next_n   = 1'b0;
      sent_n   = 1'b0;
      rdop_n   = 1'b0;
      intack_n = 1'b0;
      case (cyc_t'(req_hi[7:6]))
        CYC_PCI, CYC_PCR: begin
          if (req_hi[7:6] == CYC_PCI && intack) begin
            din_n   = rst_opcode(irq_vec);
            ready_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            rd_n    = 1'b1;
            addr_n  = {req_hi[5:0], lo};
            io_n    = 1'b0;
            ready_n = 1'b0;
            rdop_n  = 1'b1;
            state_n = ST_RD_WAIT;
          end
        end
        CYC_PCW: begin
          ready_n = 1'b1;
          state_n = ST_WR_WAIT;
        end
        default: begin
          addr_n  = {9'b0, req_hi[5:1]};
          io_n    = 1'b1;
          state_n = ST_IO_WAIT;
          if (req_hi[5:4] == 2'b00) begin
            rd_n    = 1'b1;
            ready_n = 1'b0;
            rdop_n  = 1'b1;
          end else begin
            wr_n    = 1'b1;
            wdata_n = lo;
            ready_n = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      lo        <= 8'h00;
      hi        <= 8'h00;
      intack    <= 1'b0;
      pend      <= 1'b0;
      next_cyc  <= 1'b0;
      wr_sent   <= 1'b0;
      rd_op     <= 1'b0;
      cpu_din   <= 8'h00;
      cpu_ready <= 1'b1;
      cpu_intr  <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 14'h0000;
      mem_wdata <= 8'h00;
      bus_io    <= 1'b0;
    end else begin
      state     <= state_n;
      lo        <= lo_n;
      hi        <= hi_n;
      intack    <= intack_n;
      pend      <= pend_n;
      next_cyc  <= next_n;
      wr_sent   <= sent_n;
      rd_op     <= rdop_n;
      cpu_din   <= din_n;
      cpu_ready <= ready_n;
      cpu_intr  <= intr_n;
      mem_rd    <= rd_n;
      mem_wr    <= wr_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      bus_io    <= io_n;
    end
  end

endmodule
